// File: rtl/id_ex_reg.sv
// ---------------------------------------------------------------------------
// id_ex_reg
//
// ID/EX pipeline register of the 5-stage MIPS core. It captures the decoded
// operands, the extended immediate and the control bundle, and presents them
// to EX one cycle later. It also performs WB write-through onto the register
// read data, pre-selects ALU operand B, and inserts bubbles for load-use
// hazards, external stalls and flushes.
//
// Configuration macro: IDEX_LOADUSE_EN
//   defined   - internal load-use detection and bubble insertion are active
//   undefined - ld_use is tied low, hazard_stall follows stall_in, and the
//               external hazard unit must flush/freeze on load-use itself
//
// Ports:
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   valid_id             ID slot holds a real instruction
//   rs_id, rt_id         source register numbers
//   use_rs_id, use_rt_id instruction actually reads rs / rt
//   rs_data_id,rt_data_id register-file read data
//   ext_id               extended immediate
//   dst_id               resolved destination register (0 = none)
//   pc8_id               PC+8 for link instructions
//   *_id control bits    reg_write, mem_read, mem_write, mem_to_reg, alu_src
//   alu_op_id            ALU operation
//   wb_we/wb_addr/wb_data WB register-file write port
//   stall_in             EX cannot accept, hold the register
//   flush_in             kill the ID/EX contents
//   *_ex outputs         registered validity, control, register numbers,
//                        operands, store data, immediate and PC+8
//   hazard_stall         freeze PC and IF/ID this cycle
// ---------------------------------------------------------------------------
module id_ex_reg #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           valid_id,
    input  logic [AW-1:0]  rs_id,
    input  logic [AW-1:0]  rt_id,
    input  logic           use_rs_id,
    input  logic           use_rt_id,
    input  logic [DW-1:0]  rs_data_id,
    input  logic [DW-1:0]  rt_data_id,
    input  logic [DW-1:0]  ext_id,
    input  logic [AW-1:0]  dst_id,
    input  logic [DW-1:0]  pc8_id,
    input  logic           reg_write_id,
    input  logic           mem_read_id,
    input  logic           mem_write_id,
    input  logic           mem_to_reg_id,
    input  logic           alu_src_id,
    input  logic [OPW-1:0] alu_op_id,
    input  logic           wb_we,
    input  logic [AW-1:0]  wb_addr,
    input  logic [DW-1:0]  wb_data,
    input  logic           stall_in,
    input  logic           flush_in,
    output logic           valid_ex,
    output logic           reg_write_ex,
    output logic           mem_read_ex,
    output logic           mem_write_ex,
    output logic           mem_to_reg_ex,
    output logic [OPW-1:0] alu_op_ex,
    output logic [AW-1:0]  dst_ex,
    output logic [AW-1:0]  rs_ex,
    output logic [AW-1:0]  rt_ex,
    output logic [DW-1:0]  opa_ex,
    output logic [DW-1:0]  opb_ex,
    output logic [DW-1:0]  rt_data_ex,
    output logic [DW-1:0]  ext_ex,
    output logic [DW-1:0]  pc8_ex,
    output logic           hazard_stall
);

    // Whole pipeline slot as one packed record so a bubble is simply '0.
    typedef struct packed {
        logic           valid;
        logic           reg_write;
        logic           mem_read;
        logic           mem_write;
        logic           mem_to_reg;
        logic [OPW-1:0] alu_op;
        logic [AW-1:0]  dst;
        logic [AW-1:0]  rs;
        logic [AW-1:0]  rt;
        logic [DW-1:0]  opa;
        logic [DW-1:0]  opb;
        logic [DW-1:0]  rt_data;
        logic [DW-1:0]  ext;
        logic [DW-1:0]  pc8;
    } slot_t;

    slot_t          slot_q;
    slot_t          slot_d;
    logic [DW-1:0]  rs_val;
    logic [DW-1:0]  rt_val;
    logic           ld_use;

    // Write-through: the register file reads before it writes, so a WB
    // write to the register being read this cycle must be bypassed here.
    // Register $0 is hardwired to zero and is never bypassed.
    always_comb begin
        rs_val = rs_data_id;
        rt_val = rt_data_id;
        if (wb_we && (wb_addr != '0) && (wb_addr == rs_id)) rs_val = wb_data;
        if (wb_we && (wb_addr != '0) && (wb_addr == rt_id)) rt_val = wb_data;
    end

`ifdef IDEX_LOADUSE_EN
    // A load in EX whose destination is read by the ID instruction cannot
    // be forwarded in time; one bubble lets the load reach MEM first.
    assign ld_use = slot_q.valid && slot_q.mem_read && (slot_q.dst != '0) && valid_id &&
                    ((use_rs_id && (rs_id == slot_q.dst)) ||
                     (use_rt_id && (rt_id == slot_q.dst)));
`else
    logic ld_use_unused;
    assign ld_use_unused = use_rs_id ^ use_rt_id;
    assign ld_use = 1'b0;
`endif

    assign hazard_stall = stall_in | ld_use;

    // Captured slot: control bits and destination are masked on an
    // invalid ID slot so a non-instruction can never write state. Operand B
    // is selected here so EX sees no mux delay.
    always_comb begin
        slot_d            = '0;
        slot_d.valid      = valid_id;
        slot_d.reg_write  = reg_write_id  & valid_id;
        slot_d.mem_read   = mem_read_id   & valid_id;
        slot_d.mem_write  = mem_write_id  & valid_id;
        slot_d.mem_to_reg = mem_to_reg_id & valid_id;
        slot_d.alu_op     = alu_op_id;
        slot_d.dst        = valid_id ? dst_id : '0;
        slot_d.rs         = rs_id;
        slot_d.rt         = rt_id;
        slot_d.opa        = rs_val;
        slot_d.opb        = alu_src_id ? ext_id : rt_val;
        slot_d.rt_data    = rt_val;
        slot_d.ext        = ext_id;
        slot_d.pc8        = pc8_id;
    end

    // Pipeline register: reset, then flush, then hold, then load-use
    // bubble, otherwise capture. Held values are not write-through updated;
    // EX forwarding refreshes them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else if (flush_in) begin
            slot_q <= '0;
        end else if (stall_in) begin
            slot_q <= slot_q;
        end else if (ld_use) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign valid_ex      = slot_q.valid;
    assign reg_write_ex  = slot_q.reg_write;
    assign mem_read_ex   = slot_q.mem_read;
    assign mem_write_ex  = slot_q.mem_write;
    assign mem_to_reg_ex = slot_q.mem_to_reg;
    assign alu_op_ex     = slot_q.alu_op;
    assign dst_ex        = slot_q.dst;
    assign rs_ex         = slot_q.rs;
    assign rt_ex         = slot_q.rt;
    assign opa_ex        = slot_q.opa;
    assign opb_ex        = slot_q.opb;
    assign rt_data_ex    = slot_q.rt_data;
    assign ext_ex        = slot_q.ext;
    assign pc8_ex        = slot_q.pc8;

endmodule

// File: tb/tb_id_ex_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_reg
//
// Self-checking bench for id_ex_reg. A behavioural model tracks what the EX
// side must hold after every edge; a compare process checks every output
// against it on each falling edge. Directed scenarios add literal checks.
// Honours IDEX_LOADUSE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_id_ex_reg;

    logic        clk;
    logic        rst_n;
    logic        valid_id;
    logic [4:0]  rs_id, rt_id, dst_id, wb_addr;
    logic        use_rs_id, use_rt_id;
    logic [31:0] rs_data_id, rt_data_id, ext_id, pc8_id, wb_data;
    logic        reg_write_id, mem_read_id, mem_write_id, mem_to_reg_id, alu_src_id;
    logic [3:0]  alu_op_id;
    logic        wb_we, stall_in, flush_in;
    logic        valid_ex, reg_write_ex, mem_read_ex, mem_write_ex, mem_to_reg_ex;
    logic [3:0]  alu_op_ex;
    logic [4:0]  dst_ex, rs_ex, rt_ex;
    logic [31:0] opa_ex, opb_ex, rt_data_ex, ext_ex, pc8_ex;
    logic        hazard_stall;

    int checks = 0;
    int errors = 0;
    bit checking = 0;

    id_ex_reg #(.DW(32), .AW(5), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n), .valid_id(valid_id),
        .rs_id(rs_id), .rt_id(rt_id), .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
        .rs_data_id(rs_data_id), .rt_data_id(rt_data_id), .ext_id(ext_id),
        .dst_id(dst_id), .pc8_id(pc8_id), .reg_write_id(reg_write_id),
        .mem_read_id(mem_read_id), .mem_write_id(mem_write_id),
        .mem_to_reg_id(mem_to_reg_id), .alu_src_id(alu_src_id), .alu_op_id(alu_op_id),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall_in(stall_in), .flush_in(flush_in),
        .valid_ex(valid_ex), .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex),
        .mem_write_ex(mem_write_ex), .mem_to_reg_ex(mem_to_reg_ex), .alu_op_ex(alu_op_ex),
        .dst_ex(dst_ex), .rs_ex(rs_ex), .rt_ex(rt_ex), .opa_ex(opa_ex), .opb_ex(opb_ex),
        .rt_data_ex(rt_data_ex), .ext_ex(ext_ex), .pc8_ex(pc8_ex),
        .hazard_stall(hazard_stall)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Model of the EX-side contents, one variable per visible output.
    logic        m_valid, m_rw, m_mr, m_mw, m_m2r;
    logic [3:0]  m_op;
    logic [4:0]  m_dst, m_rs, m_rt;
    logic [31:0] m_opa, m_opb, m_rtd, m_ext, m_pc8;

    function automatic logic [31:0] read_reg(input logic [4:0] a, input logic [31:0] rf);
        if (wb_we && wb_addr != 0 && wb_addr == a) return wb_data;
        return rf;
    endfunction

    function automatic logic model_ld_use();
`ifdef IDEX_LOADUSE_EN
        if (!(m_valid && m_mr && m_dst != 0 && valid_id)) return 1'b0;
        return (use_rs_id && rs_id == m_dst) || (use_rt_id && rt_id == m_dst);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_bubble();
        {m_valid, m_rw, m_mr, m_mw, m_m2r} = '0;
        m_op = 0; m_dst = 0; m_rs = 0; m_rt = 0;
        m_opa = 0; m_opb = 0; m_rtd = 0; m_ext = 0; m_pc8 = 0;
    endtask

    // Model update on each rising edge from the inputs presented before it.
    always @(posedge clk) begin
        if (!rst_n || flush_in) model_bubble();
        else if (stall_in) begin end
        else if (model_ld_use()) model_bubble();
        else begin
            m_valid = valid_id;
            m_rw  = valid_id ? reg_write_id  : 1'b0;
            m_mr  = valid_id ? mem_read_id   : 1'b0;
            m_mw  = valid_id ? mem_write_id  : 1'b0;
            m_m2r = valid_id ? mem_to_reg_id : 1'b0;
            m_dst = valid_id ? dst_id : 5'd0;
            m_op  = alu_op_id;
            m_rs  = rs_id;
            m_rt  = rt_id;
            m_opa = read_reg(rs_id, rs_data_id);
            m_rtd = read_reg(rt_id, rt_data_id);
            m_opb = alu_src_id ? ext_id : m_rtd;
            m_ext = ext_id;
            m_pc8 = pc8_id;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every output against the model on each falling edge.
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("valid_ex", 32'(valid_ex), 32'(m_valid));
            checkOutput("reg_write_ex", 32'(reg_write_ex), 32'(m_rw));
            checkOutput("mem_read_ex", 32'(mem_read_ex), 32'(m_mr));
            checkOutput("mem_write_ex", 32'(mem_write_ex), 32'(m_mw));
            checkOutput("mem_to_reg_ex", 32'(mem_to_reg_ex), 32'(m_m2r));
            checkOutput("alu_op_ex", 32'(alu_op_ex), 32'(m_op));
            checkOutput("dst_ex", 32'(dst_ex), 32'(m_dst));
            checkOutput("rs_ex", 32'(rs_ex), 32'(m_rs));
            checkOutput("rt_ex", 32'(rt_ex), 32'(m_rt));
            checkOutput("opa_ex", opa_ex, m_opa);
            checkOutput("opb_ex", opb_ex, m_opb);
            checkOutput("rt_data_ex", rt_data_ex, m_rtd);
            checkOutput("ext_ex", ext_ex, m_ext);
            checkOutput("pc8_ex", pc8_ex, m_pc8);
            checkOutput("hazard_stall", 32'(hazard_stall), 32'(stall_in | model_ld_use()));
        end
    end

    // Advance one clock edge and settle just after it.
    task automatic applyStimulus(input int edges);
        for (int i = 0; i < edges; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearInputs();
        valid_id = 0; rs_id = 0; rt_id = 0; use_rs_id = 0; use_rt_id = 0;
        rs_data_id = 0; rt_data_id = 0; ext_id = 0; dst_id = 0; pc8_id = 0;
        reg_write_id = 0; mem_read_id = 0; mem_write_id = 0; mem_to_reg_id = 0;
        alu_src_id = 0; alu_op_id = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
        stall_in = 0; flush_in = 0;
    endtask

    logic [31:0] held_opa, held_pc8;

    initial begin
        clearInputs();
        rst_n = 0;
        applyStimulus(2);
        checking = 1;
        checkOutput("reset valid_ex", 32'(valid_ex), 0);
        checkOutput("reset opa_ex", opa_ex, 0);
        rst_n = 1;

        // Plain capture
        valid_id = 1; rs_id = 1; use_rs_id = 1; rs_data_id = 32'h11;
        rt_id = 2; rt_data_id = 32'h22; ext_id = 32'hFFFF8000; alu_src_id = 1;
        dst_id = 8; reg_write_id = 1; pc8_id = 32'h108; alu_op_id = 4'h2;
        applyStimulus(1);
        checkOutput("plain opa", opa_ex, 32'h11);
        checkOutput("plain opb", opb_ex, 32'hFFFF8000);
        checkOutput("plain dst", 32'(dst_ex), 8);
        checkOutput("plain valid", 32'(valid_ex), 1);

        // Write-through on rt
        rs_id = 3; rs_data_id = 32'h33; rt_id = 9; rt_data_id = 32'h5;
        wb_we = 1; wb_addr = 9; wb_data = 32'hABCD; alu_src_id = 0;
        applyStimulus(1);
        checkOutput("wt opb", opb_ex, 32'hABCD);
        checkOutput("wt rt_data", rt_data_ex, 32'hABCD);
        checkOutput("wt opa", opa_ex, 32'h33);

        // Register 0 never write-throughs
        wb_addr = 0; rt_id = 0;
        applyStimulus(1);
        checkOutput("r0 opb", opb_ex, 32'h5);
        wb_we = 0;

        // Load into EX, then a dependent instruction in ID
        rs_id = 1; mem_read_id = 1; mem_to_reg_id = 1; dst_id = 4;
        alu_src_id = 1; ext_id = 32'h8;
        applyStimulus(1);
        checkOutput("load mem_read", 32'(mem_read_ex), 1);
        rs_id = 4; use_rs_id = 1; rs_data_id = 32'h44; rt_id = 2; use_rt_id = 0;
        mem_read_id = 0; mem_to_reg_id = 0; dst_id = 5; alu_src_id = 0;
        #1;
`ifdef IDEX_LOADUSE_EN
        checkOutput("ld_use stall", 32'(hazard_stall), 1);
        applyStimulus(1);
        checkOutput("bubble valid", 32'(valid_ex), 0);
        checkOutput("bubble reg_write", 32'(reg_write_ex), 0);
        checkOutput("after bubble stall", 32'(hazard_stall), 0);
        applyStimulus(1);
`else
        checkOutput("no ld_use stall", 32'(hazard_stall), 0);
        applyStimulus(1);
        checkOutput("no bubble valid", 32'(valid_ex), 1);
        applyStimulus(1);
`endif
        checkOutput("dep captured dst", 32'(dst_ex), 5);
        checkOutput("dep captured opa", opa_ex, 32'h44);

        // Hold for 3 cycles while ID changes and WB writes the held source
        stall_in = 1;
        held_opa = opa_ex; held_pc8 = pc8_ex;
        for (int i = 0; i < 3; i++) begin
            rs_data_id = 32'h100 + 32'(i); pc8_id = 32'h200 + 32'(i);
            wb_we = 1; wb_addr = 4; wb_data = 32'h999;
            #1;
            checkOutput("hold stall", 32'(hazard_stall), 1);
            applyStimulus(1);
            checkOutput("hold opa", opa_ex, held_opa);
            checkOutput("hold pc8", pc8_ex, held_pc8);
        end
        wb_we = 0;

        // Flush beats stall
        flush_in = 1;
        applyStimulus(1);
        checkOutput("flush valid", 32'(valid_ex), 0);
        checkOutput("flush opa", opa_ex, 0);
        flush_in = 0; stall_in = 0;

        // Load with destination 0 never creates a hazard
        rs_id = 0; rt_id = 0; dst_id = 0; mem_read_id = 1;
        applyStimulus(1);
        mem_read_id = 0;
        #1;
        checkOutput("r0 no hazard", 32'(hazard_stall), 0);

        // Load then flush with a dependent instruction
        dst_id = 6; mem_read_id = 1;
        applyStimulus(1);
        rs_id = 6; use_rs_id = 1; mem_read_id = 0; dst_id = 7; flush_in = 1;
        applyStimulus(1);
        checkOutput("flush+ld valid", 32'(valid_ex), 0);
        flush_in = 0;

        // Pseudo-random vectors with small register numbers
        for (int i = 0; i < 40; i++) begin
            valid_id = 1'($urandom_range(0, 3) != 0);
            rs_id = 5'($urandom_range(0, 3)); rt_id = 5'($urandom_range(0, 3));
            use_rs_id = 1'($urandom); use_rt_id = 1'($urandom);
            rs_data_id = $urandom; rt_data_id = $urandom; ext_id = $urandom;
            pc8_id = $urandom; dst_id = 5'($urandom_range(0, 3));
            {reg_write_id, mem_read_id, mem_write_id, mem_to_reg_id, alu_src_id} = 5'($urandom);
            alu_op_id = 4'($urandom);
            wb_we = 1'($urandom); wb_addr = 5'($urandom_range(0, 3)); wb_data = $urandom;
            stall_in = 1'($urandom_range(0, 5) == 0);
            flush_in = 1'($urandom_range(0, 7) == 0);
            applyStimulus(1);
        end
        clearInputs();

        // Reset mid-stream with stall asserted
        valid_id = 1; dst_id = 3; reg_write_id = 1; rs_data_id = 32'h77;
        applyStimulus(1);
        rst_n = 0; stall_in = 1;
        applyStimulus(1);
        checkOutput("midreset valid", 32'(valid_ex), 0);
        checkOutput("midreset opa", opa_ex, 0);
        checkOutput("midreset dst", 32'(dst_ex), 0);
        checkOutput("midreset stall", 32'(hazard_stall), 1);
        rst_n = 1; stall_in = 0;
        applyStimulus(2);

        @(negedge clk);
        checking = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register of the 5-stage MIPS core. It captures the decoded instruction's operands, the 32-bit extended immediate from the immediate extender, and the control bundle, then presents them to the EX stage one cycle later. It also:
- performs register-file write-through from WB;
- pre-selects ALU operand B;
- inserts bubbles on load-use hazards, external stall and flush.

## Interface
Parameters:
- `DW`, 32, datapath width
- `AW`, 5, register address width
- `OPW`, 4, ALU opcode width

Ports:
- `clk` input 1: core clock, rising edge
- `rst_n` input 1: synchronous active-low reset
- `valid_id` input 1: ID slot holds a real instruction
- `rs_id`, `rt_id` input AW: source register numbers
- `use_rs_id`, `use_rt_id` input 1: instruction reads rs / rt
- `rs_data_id`, `rt_data_id` input DW: register-file read data
- `ext_id` input DW: extended immediate from the extender
- `dst_id` input AW: resolved destination register (0 means none)
- `pc8_id` input DW: PC+8 for link instructions
- `reg_write_id`, `mem_read_id`, `mem_write_id`, `mem_to_reg_id`, `alu_src_id` input 1: control bits; `alu_src_id`=1 selects the immediate
- `alu_op_id` input OPW: ALU operation
- `wb_we` input 1: WB register write enable
- `wb_addr` input AW: WB write address
- `wb_data` input DW: WB write data
- `stall_in` input 1: EX cannot accept; hold the register
- `flush_in` input 1: kill the ID/EX contents
- `valid_ex`, `reg_write_ex`, `mem_read_ex`, `mem_write_ex`, `mem_to_reg_ex` output 1: registered validity and control
- `alu_op_ex` output OPW
- `dst_ex`, `rs_ex`, `rt_ex` output AW: registered register numbers, kept for forwarding
- `opa_ex` output DW: operand A (rs data after write-through)
- `opb_ex` output DW: operand B, either `ext_id` or rt data after write-through
- `rt_data_ex` output DW: rt data after write-through, used as store data
- `ext_ex`, `pc8_ex` output DW
- `hazard_stall` output 1: freeze PC and IF/ID this cycle

## Operation
- **Write-through.** When `wb_we` is set, `wb_addr`≠0 and `wb_addr` equals `rs_id`, the captured rs value is `wb_data`. The same rule applies to rt. This covers the case where the register file reads before it writes in the same cycle.
- **Operand B.** `opb_ex` = `alu_src_id` ? `ext_id` : (rt after write-through). The mux is evaluated before the register, so EX sees no mux delay.
- **Load-use hazard (`ld_use`).** Combinational; true when all of the following hold:
  - `valid_ex` & `mem_read_ex` & `dst_ex`≠0 & `valid_id`;
  - and either (`use_rs_id` & `rs_id`==`dst_ex`) or (`use_rt_id` & `rt_id`==`dst_ex`).
- **`hazard_stall`** = `stall_in` | `ld_use`.
- **Per-edge action, in priority order:**
  1. `!rst_n`: clear all outputs to 0.
  2. `flush_in`: load a bubble.
  3. `stall_in`: hold every field unchanged.
  4. `ld_use`: load a bubble.
  5. Otherwise capture all ID inputs. `valid_ex` takes `valid_id`.
- **Bubble** means every output is 0, including data fields, `dst_ex`, `valid_ex` and all control bits.
- **Masking of invalid slots.** When `valid_id`=0 and the register captures, all control bits are stored as 0 regardless of their input values, and `dst_ex` is stored as 0.

## Timing
- Capture latency is 1 cycle: ID inputs at edge N appear on the `_ex` outputs after edge N.
- `hazard_stall` is combinational from the registered EX fields and the current ID inputs. It is valid in the same cycle, with no registered delay.
- A load-use hazard produces exactly one bubble. On the next edge the load has left EX, so `ld_use` deasserts and the held ID instruction is captured.
- Reset mid-operation: on the next edge, every output is 0 and `hazard_stall` = `stall_in`.
- `flush_in` together with `stall_in`: flush wins, and a bubble is loaded.
- `flush_in` together with `ld_use`: bubble (same result). `hazard_stall` stays asserted, so upstream holds.
- `stall_in` held for many cycles: outputs stay constant. Write-through is not applied to held values. Those values are refreshed by forwarding in EX.
- Register $0 never write-throughs and never causes a load-use hazard.

## Configuration
- Macro `IDEX_LOADUSE_EN`.
- Defined: internal load-use detection and bubble insertion are active as described above.
- Undefined:
  - `ld_use` is tied to 0 and `hazard_stall` = `stall_in`.
  - The hazard unit outside this block must drive `flush_in` (bubble) and freeze upstream on load-use.
  - All other behaviour is identical.

## Test plan
- **Plain capture.** Reset, release, then present `valid_id`=1, `rs_data_id`=0x11, `ext_id`=0xFFFF8000, `alu_src_id`=1, `dst_id`=8, `reg_write_id`=1. Next cycle: `opa_ex`=0x11, `opb_ex`=0xFFFF8000, `dst_ex`=8, `valid_ex`=1.
- **Write-through.** `rt_id`=9, `rt_data_id`=0x5, `wb_we`=1, `wb_addr`=9, `wb_data`=0xABCD, `alu_src_id`=0 → `opb_ex`=`rt_data_ex`=0xABCD. Repeat with `wb_addr`=0 and `rt_id`=0 → value 0x5 is kept.
- **Load-use.** EX holds `mem_read_ex`=1, `dst_ex`=4. ID has `rs_id`=4, `use_rs_id`=1 → `hazard_stall`=1 in the same cycle. Next cycle is a bubble (`valid_ex`=0, `reg_write_ex`=0). The cycle after captures the ID instruction and `hazard_stall`=0. Build with the macro undefined → no bubble and `hazard_stall`=0.
- **Hold.** With `stall_in`=1 for 3 cycles while the ID inputs change, the outputs stay constant and `hazard_stall`=1.
- **Priority.** `flush_in`=1 together with `stall_in`=1 → bubble next cycle.
- **Reset mid-stream.** Drive `rst_n`=0 for one edge → every output is 0.
